// File: rtl/cam_pkg.sv
// Shared types and defaults for the CAM request-side controller.
package cam_pkg;

  localparam int              KEY_W_DEF        = 8;
  localparam int              DEPTH_DEF        = 8;
  localparam logic [7:0]      RESERVED_KEY_DEF = 8'hFF;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_FLUSH  = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_SWEEP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOOK  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/cam_victim_sel.sv
// Victim picker: lowest free slot wins; when the CAM is full, fall back to a
// round-robin pointer that only moves when an eviction is committed.
module cam_victim_sel #(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DEPTH-1:0]  valid_i,
  input  logic              adv_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] victim_o,
  output logic              evict_o
);

  logic [ADDR_W-1:0] rr_q;

  // Scan high-to-low so the lowest free index is the last one to win.
  always_comb begin
    victim_o = rr_q;
    evict_o  = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        victim_o = ADDR_W'(i);
        evict_o  = 1'b0;
      end
    end
  end

  // Round-robin pointer; wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_q <= '0;
    else if (clr_i)  rr_q <= '0;
    else if (adv_i)  rr_q <= rr_q + 1'b1;
  end

endmodule

// File: rtl/cam_insert_ctrl.sv
// Request-side controller for an 8-entry CAM: turns LOOKUP/INSERT/FLUSH
// commands into CAM key/we/waddr drives, tracks occupancy, and only writes on
// a miss so stored keys stay unique.
module cam_insert_ctrl
  import cam_pkg::*;
#(
  parameter  int               KEY_W        = KEY_W_DEF,
  parameter  int               DEPTH        = DEPTH_DEF,
  parameter  logic [KEY_W-1:0] RESERVED_KEY = KEY_W'(RESERVED_KEY_DEF),
  localparam int               ADDR_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [KEY_W-1:0]  req_key,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic [ADDR_W-1:0] resp_idx,
  output logic              resp_evict,
  output logic              resp_err,
  output logic              cam_we,
  output logic [ADDR_W-1:0] cam_waddr,
  output logic [KEY_W-1:0]  cam_key,
  input  logic              cam_hit,
  input  logic [ADDR_W-1:0] cam_raddr,
  output logic [ADDR_W:0]   occupancy
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              flush_q, flush_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              cam_we_q, cam_we_d;
  logic [ADDR_W-1:0] cam_waddr_q, cam_waddr_d;
  logic [KEY_W-1:0]  cam_key_q, cam_key_d;
  logic              rv_q, rv_d, rh_q, rh_d, re_q, re_d, rerr_q, rerr_d;
  logic [ADDR_W-1:0] ridx_q, ridx_d;

  logic              look_hit, rr_adv, rr_clr, v_evict;
  logic [ADDR_W-1:0] victim;

  // A CAM match only counts if the slot is live; free slots hold the filler key.
  assign look_hit = cam_hit & valid_q[cam_raddr];

  cam_victim_sel #(.DEPTH(DEPTH)) u_victim (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_q),
    .adv_i    (rr_adv),
    .clr_i    (rr_clr),
    .victim_o (victim),
    .evict_o  (v_evict)
  );

  // Next-state and output decode; CAM drives are registered so reset forces them low.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    flush_d     = flush_q;
    valid_d     = valid_q;
    cam_we_d    = 1'b0;
    cam_waddr_d = cam_waddr_q;
    cam_key_d   = cam_key_q;
    rv_d        = rv_q;
    rh_d        = rh_q;
    ridx_d      = ridx_q;
    re_d        = re_q;
    rerr_d      = rerr_q;
    rr_adv      = 1'b0;
    rr_clr      = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        cam_we_d    = 1'b1;
        cam_waddr_d = cnt_q;
        cam_key_d   = RESERVED_KEY;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          if (flush_q) begin
            flush_d = 1'b0;
            rv_d    = 1'b1;
            rh_d    = 1'b0;
            ridx_d  = '0;
            re_d    = 1'b0;
            rerr_d  = 1'b0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          op_d = op_e'(req_op);
          if (op_e'(req_op) == OP_RSVD ||
              (op_e'(req_op) != OP_FLUSH && req_key == RESERVED_KEY)) begin
            rv_d    = 1'b1;
            rh_d    = 1'b0;
            ridx_d  = '0;
            re_d    = 1'b0;
            rerr_d  = 1'b1;
            state_d = ST_RESP;
          end else if (op_e'(req_op) == OP_FLUSH) begin
            valid_d = '0;
            rr_clr  = 1'b1;
            cnt_d   = '0;
            flush_d = 1'b1;
            state_d = ST_SWEEP;
          end else begin
            cam_key_d = req_key;
            state_d   = ST_LOOK;
          end
        end
      end
      ST_LOOK: begin
        rerr_d = 1'b0;
        rh_d   = look_hit;
        if (op_q == OP_INSERT && !look_hit) begin
          cam_we_d    = 1'b1;
          cam_waddr_d = victim;
          ridx_d      = victim;
          re_d        = v_evict;
          rr_adv      = v_evict;
          state_d     = ST_WRITE;
        end else begin
          ridx_d  = look_hit ? cam_raddr : '0;
          re_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        valid_d[cam_waddr_q] = 1'b1;
        rv_d                 = 1'b1;
        state_d              = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  // State and output registers; reset restarts the sweep and drops any response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SWEEP;
      op_q        <= OP_LOOKUP;
      cnt_q       <= '0;
      flush_q     <= 1'b0;
      valid_q     <= '0;
      cam_we_q    <= 1'b0;
      cam_waddr_q <= '0;
      cam_key_q   <= '0;
      rv_q        <= 1'b0;
      rh_q        <= 1'b0;
      ridx_q      <= '0;
      re_q        <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      valid_q     <= valid_d;
      cam_we_q    <= cam_we_d;
      cam_waddr_q <= cam_waddr_d;
      cam_key_q   <= cam_key_d;
      rv_q        <= rv_d;
      rh_q        <= rh_d;
      ridx_q      <= ridx_d;
      re_q        <= re_d;
      rerr_q      <= rerr_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = rv_q;
  assign resp_hit   = rh_q;
  assign resp_idx   = ridx_q;
  assign resp_evict = re_q;
  assign resp_err   = rerr_q;
  assign cam_we     = cam_we_q;
  assign cam_waddr  = cam_waddr_q;
  assign cam_key    = cam_key_q;
  assign occupancy  = (ADDR_W + 1)'($countones(valid_q));

endmodule

// File: tb/tb_cam_insert_ctrl.sv
// Bench: controller wired to a behavioural CAM; responses checked by a
// scoreboard fed from a key/slot reference model.
module tb_cam_insert_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0] req_op;
  logic [7:0] req_key, cam_key;
  logic       resp_hit, resp_evict, resp_err, cam_we, cam_hit;
  logic [2:0] resp_idx, cam_waddr, cam_raddr;
  logic [3:0] occupancy;

  always #5 clk = ~clk;

  cam_insert_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_idx(resp_idx), .resp_evict(resp_evict), .resp_err(resp_err),
    .cam_we(cam_we), .cam_waddr(cam_waddr), .cam_key(cam_key),
    .cam_hit(cam_hit), .cam_raddr(cam_raddr), .occupancy(occupancy)
  );

  // Behavioural CAM: synchronous write, combinational lowest-index match.
  logic [7:0] cmem [8];
  always @(posedge clk) if (cam_we) cmem[cam_waddr] <= cam_key;
  always_comb begin
    cam_hit   = 1'b0;
    cam_raddr = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (cmem[i] == cam_key) begin cam_hit = 1'b1; cam_raddr = 3'(i); end
  end

  int tests = 0, fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Reference model: which key lives in which slot, plus the round-robin pointer.
  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
    logic       evict;
    logic       err;
    logic [3:0] occ;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] m_key [8];
  bit         m_v   [8];
  int         m_rr;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_v[i] = 0;
    m_rr = 0;
  endtask

  task automatic push_exp(input logic [1:0] op, input logic [7:0] key);
    exp_t e;
    int   h, fr;
    e = '0;
    if (op == 2'd3 || (op != 2'd2 && key == 8'hFF)) e.err = 1'b1;
    else if (op == 2'd2) model_reset();
    else begin
      h = -1;
      for (int i = 0; i < 8; i++) if (m_v[i] && m_key[i] == key && h < 0) h = i;
      if (h >= 0) begin
        e.hit = 1'b1;
        e.idx = 3'(h);
      end else if (op == 2'd1) begin
        fr = -1;
        for (int i = 0; i < 8; i++) if (!m_v[i] && fr < 0) fr = i;
        if (fr < 0) begin
          fr      = m_rr;
          m_rr    = (m_rr + 1) % 8;
          e.evict = 1'b1;
        end
        m_v[fr]   = 1;
        m_key[fr] = key;
        e.idx     = 3'(fr);
      end
    end
    e.occ = 0;
    for (int i = 0; i < 8; i++) e.occ = e.occ + 4'(m_v[i]);
    expq.push_back(e);
  endtask

  // Scoreboard monitor: pop and compare on every completed response handshake.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (expq.size() == 0) timeout("resp_unexpected");
      else begin
        mon_e = expq.pop_front();
        check("resp_hit",   32'(resp_hit),   32'(mon_e.hit));
        check("resp_idx",   32'(resp_idx),   32'(mon_e.idx));
        check("resp_evict", 32'(resp_evict), 32'(mon_e.evict));
        check("resp_err",   32'(resp_err),   32'(mon_e.err));
        check("occupancy",  32'(occupancy),  32'(mon_e.occ));
      end
    end
  end

  // CAM write monitor: counts all writes and filler writes per slot.
  int         we_cnt, ff_cnt;
  logic [7:0] ff_mask;
  always @(negedge clk) begin
    if (!rst_n) begin
      we_cnt  = 0;
      ff_cnt  = 0;
      ff_mask = '0;
    end else if (cam_we) begin
      we_cnt++;
      if (cam_key == 8'hFF) begin
        ff_cnt++;
        ff_mask[cam_waddr] = 1'b1;
      end
    end
  end

  task automatic wait_sweep();
    int n = 0;
    while (!req_ready && n < 100) begin n++; @(posedge clk); #1; end
    check("sweep_ready_low_cycles", 32'(n), 32'd8);
    @(posedge clk); #1;
    check("sweep_ff_writes", 32'(ff_cnt), 32'd8);
    check("sweep_ff_slots",  32'(ff_mask), 32'hFF);
    check("sweep_occupancy", 32'(occupancy), 32'd0);
  endtask

  // Issue one command; lat = rising edges after acceptance until resp_valid.
  task automatic do_req(input logic [1:0] op, input logic [7:0] key, output int lat);
    int n = 0;
    lat = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin timeout("req_ready"); return; end
    req_valid = 1'b1; req_op = op; req_key = key;
    push_exp(op, key);
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) begin timeout("resp_valid"); return; end
    if (resp_ready) begin @(posedge clk); #1; end
  endtask

  int lat, we0, ff0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_key = 8'd0; resp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_cam_we",     32'(cam_we),     32'd0);
    check("rst_occupancy",  32'(occupancy),  32'd0);
    rst_n = 1'b1;
    wait_sweep();

    do_req(2'd1, 8'h11, lat);
    check("ins_miss_latency", 32'(lat), 32'd2);
    we0 = we_cnt;
    do_req(2'd1, 8'h11, lat);
    check("ins_hit_no_we", 32'(we_cnt), 32'(we0));
    check("ins_hit_latency", 32'(lat), 32'd1);

    ff0 = ff_cnt;
    do_req(2'd2, 8'h00, lat);
    check("flush_latency", 32'(lat), 32'd8);
    check("flush_ff_writes", 32'(ff_cnt - ff0), 32'd8);

    for (int k = 0; k < 8; k++) do_req(2'd1, 8'h20 + 8'(k), lat);
    check("fill_occupancy", 32'(occupancy), 32'd8);
    do_req(2'd1, 8'h30, lat);
    do_req(2'd1, 8'h31, lat);

    we0 = we_cnt;
    do_req(2'd0, 8'hFF, lat);
    check("err_key_latency", 32'(lat), 32'd0);
    do_req(2'd3, 8'h12, lat);
    check("err_no_we", 32'(we_cnt), 32'(we0));
    do_req(2'd0, 8'h55, lat);
    check("lookup_latency", 32'(lat), 32'd1);

    // Back-pressure: response must hold against the model while not accepted.
    resp_ready = 1'b0;
    do_req(2'd0, 8'h22, lat);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_ready", 32'(req_ready),  32'd0);
      check("stall_hit",   32'(resp_hit),   32'(expq[0].hit));
      check("stall_idx",   32'(resp_idx),   32'(expq[0].idx));
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_drained", 32'(expq.size()), 32'd0);

    do_req(2'd2, 8'h00, lat);
    check("flush_occupancy", 32'(occupancy), 32'd0);
    do_req(2'd0, 8'h20, lat);

    for (int k = 0; k < 150; k++) begin
      int r;
      logic [1:0] op;
      logic [7:0] key;
      r   = int'($urandom_range(0, 99));
      op  = (r < 45) ? 2'd0 : (r < 90) ? 2'd1 : (r < 93) ? 2'd2 : 2'd3;
      key = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'h40 + 8'($urandom_range(0, 11));
      do_req(op, key, lat);
    end

    // Reset while the WRITE cycle is driving the CAM.
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_op = 2'd1; req_key = 8'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("write_cam_we", 32'(cam_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_cam_we",     32'(cam_we),     32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_occupancy",  32'(occupancy),  32'd0);
    model_reset();
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_sweep();
    do_req(2'd1, 8'h99, lat);
    check("post_rst_ins_latency", 32'(lat), 32'd2);
    do_req(2'd0, 8'h99, lat);

    repeat (3) @(posedge clk); #1;
    check("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
